// File: rtl/keypad_multitap_encoder.sv
// Scanned-matrix keypad front end: column scan, frame debounce, multi-tap letter decode,
// letter commit on confirm / key change / timeout, and word submit on control long press.
module keypad_multitap_encoder #(
  parameter int unsigned NUM_ROWS     = 4,
  parameter int unsigned NUM_COLS     = 2,
  parameter int unsigned TAPS_PER_KEY = 4,
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned DEBOUNCE     = 3,
  parameter int unsigned TAP_TIMEOUT  = 64,
  parameter int unsigned LONG_PRESS   = 32
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] scan_col,
  output logic [7:0]          preview,
  output logic [7:0]          letter_out,
  output logic                letter_valid,
  output logic                word_submit,
  output logic                busy
);

  localparam int unsigned NumKeys = NUM_ROWS * NUM_COLS;
  localparam int unsigned KeyW    = (NumKeys > 1) ? $clog2(NumKeys) : 1;
  localparam int unsigned ColW    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int unsigned DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned TapW    = (TAPS_PER_KEY > 1) ? $clog2(TAPS_PER_KEY) : 1;
  localparam int unsigned DbW     = $clog2(DEBOUNCE + 1);
  localparam int unsigned TmoW    = $clog2(TAP_TIMEOUT + 1);
  localparam int unsigned HoldW   = $clog2(LONG_PRESS + 1);
  localparam logic [KeyW-1:0] CtrlKey = KeyW'(NumKeys - 1);

  typedef enum logic [1:0] {StIdle, StTapping, StHoldCtrl} state_e;

  function automatic int unsigned code_of(input int unsigned k, input int unsigned t);
    return 32'd65 + k * TAPS_PER_KEY + t;
  endfunction

  // Scan and synchroniser state
  logic [DivW-1:0]     div_q, div_d;
  logic [ColW-1:0]     col_q, col_d;
  logic [NUM_ROWS-1:0] row_s1_q, row_s2_q;
  logic [ColW-1:0]     col_s1_q, col_s2_q;
  logic                last_s1_q, last_s2_q;
  logic                slot_last;
  logic [NumKeys-1:0]  acc_q, frame_cur;
  logic                frame_done;

  // Debounce state
  logic [NumKeys-1:0]  cand_q, cand_d;
  logic [DbW-1:0]      stab_q, stab_d;
  logic                held_q, held_d;
  logic                is_none, is_single;
  logic [KeyW-1:0]     key_idx;
  logic                press_evt, release_evt;

  // Letter FSM state
  state_e              state_q, state_d;
  logic [KeyW-1:0]     key_q, key_d;
  logic [TapW-1:0]     tap_q, tap_d, tap_nxt;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [7:0]          preview_q, preview_d;
  logic [7:0]          letter_q, letter_d;
  logic                valid_q, valid_d;
  logic                submit_q, submit_d;
  logic                is_ctrl, letter_press;

  always_comb begin
    slot_last = (div_q == DivW'(SCAN_DIV - 1));
    div_d     = div_q + 1'b1;
    col_d     = col_q;
    if (slot_last) begin
      div_d = '0;
      col_d = (col_q == ColW'(NUM_COLS - 1)) ? '0 : col_q + 1'b1;
    end
    scan_col        = '0;
    scan_col[col_q] = 1'b1;
  end

  // The column tag and slot-last flag travel through the synchroniser alongside the rows,
  // so each synchronised sample is attributed to the column that was driven when it was taken.
  always_comb begin
    frame_cur = acc_q;
    if (last_s2_q) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        frame_cur[r * NUM_COLS + int'(col_s2_q)] = row_s2_q[r];
      end
    end
    frame_done = last_s2_q && (col_s2_q == ColW'(NUM_COLS - 1));
    is_none    = (frame_cur == '0);
    is_single  = !is_none && ((frame_cur & (frame_cur - NumKeys'(1))) == '0);
    key_idx    = '0;
    for (int k = 0; k < NumKeys; k++) begin
      if (frame_cur[k]) key_idx = KeyW'(k);
    end
  end

  always_comb begin
    cand_d      = cand_q;
    stab_d      = stab_q;
    held_d      = held_q;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    if (frame_done) begin
      if (!is_none && !is_single) begin
        cand_d = frame_cur;
        stab_d = '0;
      end else begin
        if (frame_cur == cand_q) begin
          stab_d = (stab_q == DbW'(DEBOUNCE)) ? stab_q : stab_q + 1'b1;
        end else begin
          cand_d = frame_cur;
          stab_d = DbW'(1);
        end
        if (stab_d == DbW'(DEBOUNCE)) begin
          if (is_single && !held_q) begin
            press_evt = 1'b1;
            held_d    = 1'b1;
          end else if (is_none && held_q) begin
            release_evt = 1'b1;
            held_d      = 1'b0;
          end
        end
      end
    end
  end

  // Next tap wraps to 0 past the last tap of the key or past 'Z'.
  always_comb begin
    tap_nxt = '0;
    if ((int'(tap_q) + 1 < TAPS_PER_KEY) && (code_of(int'(key_q), int'(tap_q) + 1) <= 32'd90)) begin
      tap_nxt = tap_q + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    tap_d        = tap_q;
    tmo_d        = tmo_q;
    hold_d       = hold_q;
    preview_d    = preview_q;
    letter_d     = letter_q;
    valid_d      = 1'b0;
    submit_d     = 1'b0;
    is_ctrl      = (key_idx == CtrlKey);
    letter_press = press_evt && !is_ctrl && (code_of(int'(key_idx), 0) <= 32'd90);
    unique case (state_q)
      StIdle: begin
        if (press_evt && is_ctrl) begin
          state_d = StHoldCtrl;
          hold_d  = '0;
        end else if (letter_press) begin
          state_d   = StTapping;
          key_d     = key_idx;
          tap_d     = '0;
          tmo_d     = '0;
          preview_d = 8'(code_of(int'(key_idx), 0));
        end
      end
      StTapping: begin
        if (press_evt && is_ctrl) begin
          letter_d  = preview_q;
          valid_d   = 1'b1;
          preview_d = 8'h00;
          state_d   = StHoldCtrl;
          hold_d    = '0;
        end else if (letter_press) begin
          tmo_d = '0;
          if (key_idx == key_q) begin
            tap_d     = tap_nxt;
            preview_d = 8'(code_of(int'(key_q), int'(tap_nxt)));
          end else begin
            letter_d  = preview_q;
            valid_d   = 1'b1;
            key_d     = key_idx;
            tap_d     = '0;
            preview_d = 8'(code_of(int'(key_idx), 0));
          end
        end else if (frame_done) begin
          if (int'(tmo_q) + 1 >= TAP_TIMEOUT) begin
            letter_d  = preview_q;
            valid_d   = 1'b1;
            preview_d = 8'h00;
            state_d   = StIdle;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      StHoldCtrl: begin
        if (release_evt) begin
          state_d = StIdle;
        end else if (frame_done && (hold_q != HoldW'(LONG_PRESS))) begin
          hold_d   = hold_q + 1'b1;
          submit_d = (hold_d == HoldW'(LONG_PRESS));
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      div_q     <= '0;
      col_q     <= '0;
      row_s1_q  <= '0;
      row_s2_q  <= '0;
      col_s1_q  <= '0;
      col_s2_q  <= '0;
      last_s1_q <= 1'b0;
      last_s2_q <= 1'b0;
      acc_q     <= '0;
      cand_q    <= '0;
      stab_q    <= '0;
      held_q    <= 1'b0;
      state_q   <= StIdle;
      key_q     <= '0;
      tap_q     <= '0;
      tmo_q     <= '0;
      hold_q    <= '0;
      preview_q <= 8'h00;
      letter_q  <= 8'h00;
      valid_q   <= 1'b0;
      submit_q  <= 1'b0;
    end else begin
      div_q     <= div_d;
      col_q     <= col_d;
      row_s1_q  <= row;
      row_s2_q  <= row_s1_q;
      col_s1_q  <= col_q;
      col_s2_q  <= col_s1_q;
      last_s1_q <= slot_last;
      last_s2_q <= last_s1_q;
      acc_q     <= frame_cur;
      cand_q    <= cand_d;
      stab_q    <= stab_d;
      held_q    <= held_d;
      state_q   <= state_d;
      key_q     <= key_d;
      tap_q     <= tap_d;
      tmo_q     <= tmo_d;
      hold_q    <= hold_d;
      preview_q <= preview_d;
      letter_q  <= letter_d;
      valid_q   <= valid_d;
      submit_q  <= submit_d;
    end
  end

  assign preview      = preview_q;
  assign letter_out   = letter_q;
  assign letter_valid = valid_q;
  assign word_submit  = submit_q;
  assign busy         = (state_q == StTapping);

endmodule
